// File: rtl/bisr_test_scheduler_pkg.sv
// Shared BISR types: scheduler state enum, row-index width helper.
// Default array geometry comes from ROWS/COLS macros when not predefined.
`ifndef ROWS
`define ROWS 4
`endif
`ifndef COLS
`define COLS 4
`endif

package bisr_test_scheduler_pkg;

  localparam int DEF_ROWS = `ROWS;
  localparam int DEF_COLS = `COLS;

  function automatic int row_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROW_W = row_w(DEF_ROWS);

  typedef enum logic [2:0] {
    IDLE,
    TEST_REQ,
    TEST_WAIT,
    MAP,
    RUN_REQ,
    RUN_WAIT
  } state_t;

endpackage

// File: rtl/bisr_test_scheduler_if.sv
// Host / matmul FSM / STW / repair-map bundle of the BISR scheduler.
// master: scheduler side; slave: host, matmul FSM and STW engine side.
interface bisr_test_scheduler_if
  import bisr_test_scheduler_pkg::*;
#(
  parameter int ROWS = `ROWS,
  parameter int COLS = `COLS
);
  localparam int RW = row_w(ROWS);

  logic                 matmul_req;
  logic                 matmul_ack;
  logic                 test_req;
  logic                 fsm_rdy;
  logic                 fsm_done;
  logic                 start_matmul;
  logic                 stw_start;
  logic                 stw_complete;
  logic [ROWS*COLS-1:0] stw_result_mat;
  logic [COLS-1:0]      fpe_valid;
  logic [COLS*RW-1:0]   fpe_row;
  logic                 uncorrectable;
  logic                 test_timeout;
  logic                 busy;

  modport master (
    input  matmul_req, test_req, fsm_rdy, fsm_done,
    input  stw_complete, stw_result_mat,
    output matmul_ack, start_matmul, stw_start,
    output fpe_valid, fpe_row, uncorrectable,
    output test_timeout, busy
  );

  modport slave (
    output matmul_req, test_req, fsm_rdy, fsm_done,
    output stw_complete, stw_result_mat,
    input  matmul_ack, start_matmul, stw_start,
    input  fpe_valid, fpe_row, uncorrectable,
    input  test_timeout, busy
  );

endinterface

// File: rtl/bisr_col_fault_encoder.sv
// Column fault encoder: col (ROWS bits) -> idx (lowest faulty row),
// valid (any fault), multi (two or more faults).
module bisr_col_fault_encoder
  import bisr_test_scheduler_pkg::*;
#(
  parameter int ROWS = `ROWS,
  localparam int RW = row_w(ROWS)
) (
  input  logic [ROWS-1:0] col,
  output logic [RW-1:0]   idx,
  output logic            valid,
  output logic            multi
);

  // Scan high to low so the lowest set row wins.
  always_comb begin
    idx = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (col[r]) idx = RW'(r);
    end
  end

  assign valid = |col;
  // Clearing the lowest set bit leaves something only if 2+ bits set.
  assign multi = |(col & (col - ROWS'(1)));

endmodule

// File: rtl/bisr_test_scheduler.sv
// BISR scheduler: interleaves host matmuls with power-on, forced and
// periodic STW self-tests; builds the per-column proxy repair map.
module bisr_test_scheduler
  import bisr_test_scheduler_pkg::*;
#(
  parameter int ROWS          = `ROWS,
  parameter int COLS          = `COLS,
  parameter int TEST_INTERVAL = 4,
  parameter int TIMEOUT       = 1024
) (
  input logic            clk,
  input logic            rst,
  bisr_test_scheduler_if.master bus
);

  localparam int RW = row_w(ROWS);
  localparam int CW = row_w(COLS);
  localparam int TW = row_w(TIMEOUT);

  state_t               state;
  logic                 pending;
  logic [7:0]           mcnt;
  logic [TW-1:0]        tcnt;
  logic [CW-1:0]        mcol;
  logic                 commit;
  logic [ROWS*COLS-1:0] res_q;
  logic [COLS-1:0]      sh_valid;
  logic [RW-1:0]        sh_row [COLS];

  logic [ROWS-1:0]      col_vec;
  logic [RW-1:0]        enc_idx;
  logic                 enc_valid;
  logic                 enc_multi;

  always_comb begin
    col_vec = '0;
    for (int c = 0; c < COLS; c++) begin
      if (mcol == CW'(c)) col_vec = res_q[c*ROWS +: ROWS];
    end
  end

  bisr_col_fault_encoder #(
    .ROWS (ROWS)
  ) u_enc (
    .col   (col_vec),
    .idx   (enc_idx),
    .valid (enc_valid),
    .multi (enc_multi)
  );

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      pending           <= 1'b1;
      mcnt              <= '0;
      tcnt              <= '0;
      mcol              <= '0;
      commit            <= 1'b0;
      res_q             <= '0;
      sh_valid          <= '0;
      for (int c = 0; c < COLS; c++) sh_row[c] <= '0;
      bus.start_matmul  <= 1'b0;
      bus.stw_start     <= 1'b0;
      bus.matmul_ack    <= 1'b0;
      bus.fpe_valid     <= '0;
      bus.fpe_row       <= '0;
      bus.uncorrectable <= 1'b0;
      bus.test_timeout  <= 1'b0;
    end else begin
      bus.start_matmul <= 1'b0;
      bus.stw_start    <= 1'b0;
      bus.matmul_ack   <= 1'b0;
      unique case (state)
        IDLE: begin
          // stw_start is raised on entry so it is high while in TEST_REQ.
          // A request being acked this cycle is already consumed.
          if (pending) begin
            state         <= TEST_REQ;
            bus.stw_start <= 1'b1;
          end else if (bus.matmul_req && !bus.matmul_ack) begin
            state <= RUN_REQ;
          end
        end
        TEST_REQ: begin
          tcnt    <= '0;
          pending <= 1'b0;
          state   <= TEST_WAIT;
        end
        TEST_WAIT: begin
          if (bus.stw_complete) begin
            res_q  <= bus.stw_result_mat;
            mcol   <= '0;
            commit <= 1'b0;
            state  <= MAP;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            bus.test_timeout <= 1'b1;
            state            <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        MAP: begin
          if (!commit) begin
            sh_valid[mcol] <= enc_valid;
            sh_row[mcol]   <= enc_idx;
            if (enc_multi) bus.uncorrectable <= 1'b1;
            if (mcol == CW'(COLS - 1)) commit <= 1'b1;
            else mcol <= mcol + 1'b1;
          end else begin
            // Whole map becomes visible in one cycle.
            bus.fpe_valid <= sh_valid;
            for (int c = 0; c < COLS; c++) begin
              bus.fpe_row[c*RW +: RW] <= sh_row[c];
            end
            state <= IDLE;
          end
        end
        RUN_REQ: begin
          if (bus.fsm_rdy) begin
            bus.start_matmul <= 1'b1;
            state            <= RUN_WAIT;
          end
        end
        RUN_WAIT: begin
          if (bus.fsm_done) begin
            bus.matmul_ack <= 1'b1;
            state          <= IDLE;
            if (mcnt == 8'(TEST_INTERVAL - 1)) begin
              mcnt    <= '0;
              pending <= 1'b1;
            end else begin
              mcnt <= mcnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Placed last so a request never gets lost to the TEST_REQ clear.
      if (bus.test_req) pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bisr_test_scheduler.sv
// Directed self-checking bench for bisr_test_scheduler.
// ROWS=COLS=4, TEST_INTERVAL=2, TIMEOUT=64.
module tb_bisr_test_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  bisr_test_scheduler_if #(.ROWS(4), .COLS(4)) bus ();

  bisr_test_scheduler #(
    .ROWS          (4),
    .COLS          (4),
    .TEST_INTERVAL (2),
    .TIMEOUT       (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_stw(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (bus.stw_start) begin
        seen = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic wait_idle(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (!bus.busy) begin
        seen = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic pulse_test_req;
    bus.test_req = 1'b1;
    tick();
    bus.test_req = 1'b0;
  endtask

  // Wait for stw_start, answer with mat, wait for the map commit.
  task automatic run_test(input logic [15:0] mat, output bit ok);
    bit s1;
    bit s2;
    wait_stw(20, s1);
    tick();
    bus.stw_result_mat = mat;
    bus.stw_complete   = 1'b1;
    tick();
    bus.stw_complete = 1'b0;
    wait_idle(12, s2);
    ok = s1 && s2;
  endtask

  task automatic test_reset;
    logic [15:0] o;
    rst = 1'b1;
    bus.matmul_req     = 1'b0;
    bus.test_req       = 1'b0;
    bus.fsm_rdy        = 1'b0;
    bus.fsm_done       = 1'b0;
    bus.stw_complete   = 1'b0;
    bus.stw_result_mat = '0;
    repeat (3) tick();
    o = {bus.start_matmul, bus.stw_start, bus.matmul_ack,
         bus.uncorrectable, bus.test_timeout, bus.busy,
         bus.fpe_valid, 6'b0};
    checks++;
    if (o !== 16'h0) begin
      fails++;
      $display("FAIL reset_ctl got %h want 0000", o);
    end
    checks++;
    if (bus.fpe_row !== 8'h00) begin
      fails++;
      $display("FAIL reset_fpe_row got %h want 00", bus.fpe_row);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.stw_start !== 1'b1) begin
      fails++;
      $display("FAIL poweron_stw got %b want 1", bus.stw_start);
    end
    tick();
    checks++;
    if ({bus.stw_start, bus.busy} !== 2'b01) begin
      fails++;
      $display("FAIL stw_one_cycle got %b want 01",
               {bus.stw_start, bus.busy});
    end
    bus.stw_result_mat = 16'h0000;
    bus.stw_complete   = 1'b1;
    tick();
    bus.stw_complete = 1'b0;
    repeat (4) tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL map_busy got %b want 1", bus.busy);
    end
    tick();
    checks++;
    if ({bus.busy, bus.fpe_valid} !== 5'b0_0000) begin
      fails++;
      $display("FAIL poweron_map got %b want 00000",
               {bus.busy, bus.fpe_valid});
    end
  endtask

  task automatic test_single_fault;
    bit ok;
    pulse_test_req();
    run_test(16'h0200, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL single_timing got %b want 1", ok);
    end
    checks++;
    if ({bus.fpe_valid, bus.fpe_row, bus.uncorrectable} !==
        {4'b0100, 8'h10, 1'b0}) begin
      fails++;
      $display("FAIL single_map got %b/%h/%b want 0100/10/0",
               bus.fpe_valid, bus.fpe_row, bus.uncorrectable);
    end
  endtask

  task automatic test_multi_fault;
    bit ok;
    pulse_test_req();
    run_test(16'h5000, ok);
    checks++;
    if ({ok, bus.fpe_valid, bus.fpe_row, bus.uncorrectable} !==
        {1'b1, 4'b1000, 8'h00, 1'b1}) begin
      fails++;
      $display("FAIL multi_map got %b/%b/%h/%b want 1/1000/00/1",
               ok, bus.fpe_valid, bus.fpe_row, bus.uncorrectable);
    end
    // A stray completion while idle must not touch the map.
    bus.stw_result_mat = 16'hFFFF;
    bus.stw_complete   = 1'b1;
    tick();
    bus.stw_complete = 1'b0;
    tick();
    checks++;
    if ({bus.busy, bus.fpe_valid} !== 5'b0_1000) begin
      fails++;
      $display("FAIL stray_cpl got %b want 01000",
               {bus.busy, bus.fpe_valid});
    end
    pulse_test_req();
    run_test(16'h0000, ok);
    checks++;
    if ({ok, bus.fpe_valid, bus.uncorrectable} !== 6'b1_0000_1) begin
      fails++;
      $display("FAIL unc_sticky got %b want 100001",
               {ok, bus.fpe_valid, bus.uncorrectable});
    end
  endtask

  task automatic test_back_to_back;
    int starts;
    int acks;
    int stw_starts;
    int stw_acks;
    int done_cd;
    int cpl_cd;
    starts     = 0;
    acks       = 0;
    stw_starts = -1;
    stw_acks   = -1;
    done_cd    = 0;
    cpl_cd     = 0;
    bus.fsm_rdy    = 1'b1;
    bus.matmul_req = 1'b1;
    bus.stw_result_mat = 16'h0000;
    for (int i = 0; i < 100 && starts < 3; i++) begin
      bus.fsm_done     = 1'b0;
      bus.stw_complete = 1'b0;
      if (done_cd > 0) begin
        done_cd--;
        if (done_cd == 0) bus.fsm_done = 1'b1;
      end
      if (cpl_cd > 0) begin
        cpl_cd--;
        if (cpl_cd == 0) bus.stw_complete = 1'b1;
      end
      if (bus.matmul_ack) acks++;
      if (bus.stw_start && stw_starts < 0) begin
        stw_starts = starts;
        stw_acks   = acks;
        cpl_cd     = 1;
      end
      if (bus.start_matmul) begin
        starts++;
        done_cd = 1;
      end
      if (starts < 3) tick();
    end
    bus.matmul_req = 1'b0;
    checks++;
    if (starts !== 3) begin
      fails++;
      $display("FAIL b2b_starts got %0d want 3", starts);
    end
    checks++;
    if ({stw_starts, stw_acks} !== {32'd2, 32'd2}) begin
      fails++;
      $display("FAIL b2b_stw_order got starts=%0d acks=%0d want 2/2",
               stw_starts, stw_acks);
    end
    bus.fsm_done = 1'b0;
    tick();
    bus.fsm_done = 1'b1;
    tick();
    bus.fsm_done = 1'b0;
    checks++;
    if (bus.matmul_ack !== 1'b1) begin
      fails++;
      $display("FAIL b2b_third_ack got %b want 1", bus.matmul_ack);
    end
    tick();
  endtask

  task automatic test_timeout;
    bit ok;
    bit seen;
    pulse_test_req();
    run_test(16'h0200, ok);
    checks++;
    if ({ok, bus.fpe_valid} !== 5'b1_0100) begin
      fails++;
      $display("FAIL to_setup got %b want 10100", {ok, bus.fpe_valid});
    end
    pulse_test_req();
    wait_stw(20, seen);
    repeat (64) tick();
    checks++;
    if ({seen, bus.test_timeout, bus.busy} !== 3'b101) begin
      fails++;
      $display("FAIL to_early got %b want 101",
               {seen, bus.test_timeout, bus.busy});
    end
    tick();
    checks++;
    if ({bus.test_timeout, bus.busy} !== 2'b10) begin
      fails++;
      $display("FAIL to_flag got %b want 10",
               {bus.test_timeout, bus.busy});
    end
    checks++;
    if ({bus.fpe_valid, bus.fpe_row} !== {4'b0100, 8'h10}) begin
      fails++;
      $display("FAIL to_keep_map got %b/%h want 0100/10",
               bus.fpe_valid, bus.fpe_row);
    end
    bus.matmul_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.start_matmul) seen = 1'b1;
      else tick();
    end
    bus.fsm_done = 1'b1;
    tick();
    bus.fsm_done   = 1'b0;
    bus.matmul_req = 1'b0;
    checks++;
    if ({seen, bus.matmul_ack} !== 2'b11) begin
      fails++;
      $display("FAIL to_serve got %b want 11", {seen, bus.matmul_ack});
    end
    tick();
  endtask

  task automatic test_reset_mid;
    bit seen;
    logic [15:0] o;
    bus.matmul_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      bus.stw_complete = bus.busy && !bus.stw_start;
      if (bus.start_matmul) seen = 1'b1;
      else tick();
    end
    bus.stw_complete = 1'b0;
    rst          = 1'b1;
    bus.fsm_done = 1'b1;
    tick();
    bus.fsm_done   = 1'b0;
    bus.matmul_req = 1'b0;
    o = {bus.start_matmul, bus.stw_start, bus.matmul_ack,
         bus.uncorrectable, bus.test_timeout, bus.busy,
         bus.fpe_valid, 6'b0};
    checks++;
    if ({seen, o, bus.fpe_row} !== {1'b1, 16'h0, 8'h00}) begin
      fails++;
      $display("FAIL mid_rst got %b/%h/%h want 1/0000/00",
               seen, o, bus.fpe_row);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.stw_start !== 1'b1) begin
      fails++;
      $display("FAIL mid_rst_poweron got %b want 1", bus.stw_start);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_single_fault();
    test_multi_fault();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
